// File: rtl/mmio_timer_bank_if.sv
// Bus bundle between the CPU pipeline and the timer bank.
// Carries the store side, the combinational read-back and the interrupt outputs.
interface mmio_timer_bank_if;
  logic [31:0] abus;
  logic [31:0] wdata;
  logic        we;
  logic        ie;
  logic [31:0] rdata;
  logic        rsel;
  logic        irq;
  logic [3:0]  idn;

  modport master (output abus, wdata, we, ie, input rdata, rsel, irq, idn);
  modport slave  (input abus, wdata, we, ie, output rdata, rsel, irq, idn);
endinterface

// File: rtl/mmio_timer_bank.sv
// Bank of memory-mapped timer channels sharing one prescaler, with sticky READY/OVR and a prioritised interrupt id.
// Define TIMER_BANK_CAPTURE_EN to add the per-channel CAP register (snapshot of CNT on a CTL write with bit 5 set).
module mmio_timer_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hF0000020,
  parameter int          PRESCALE  = 50000
) (
  input logic              clk,
  input logic              rst,
  mmio_timer_bank_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescQ, prescD;
  logic          tick;

  logic [31:0] offset;
  logic [3:0]  chSel;
  logic [1:0]  regSel;
  logic        hit;

  logic [CNT_W-1:0]  cntQ [NUM_CH];
  logic [CNT_W-1:0]  cntD [NUM_CH];
  logic [CNT_W-1:0]  limQ [NUM_CH];
  logic [CNT_W-1:0]  limD [NUM_CH];
  logic [NUM_CH-1:0] enQ, enD, autoQ, autoD, ienQ, ienD;
  logic [NUM_CH-1:0] readyQ, readyD, ovrQ, ovrD;
  logic [NUM_CH-1:0] expire, cntWr, limWr, ctlWr, pend;
`ifdef TIMER_BANK_CAPTURE_EN
  logic [CNT_W-1:0]  capQ [NUM_CH];
  logic [CNT_W-1:0]  capD [NUM_CH];
`endif

  logic [31:0] rdataC;
  logic [3:0]  idnC;

  assign tick   = (prescQ == PRESC_LAST);
  assign prescD = tick ? '0 : prescQ + PW'(1);

  // An address below the base wraps to a huge offset, so one compare covers both ends.
  assign offset = bus.abus - BASE_ADDR;
  assign hit    = (offset < 32'(16 * NUM_CH));
  assign chSel  = offset[7:4];
  assign regSel = offset[3:2];

  always_comb begin
    expire = '0;
    cntWr  = '0;
    limWr  = '0;
    ctlWr  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      expire[n] = tick && enQ[n] && (cntQ[n] == limQ[n]);
      if (bus.we && hit && (chSel == 4'(n))) begin
        cntWr[n] = (regSel == 2'd0);
        limWr[n] = (regSel == 2'd1);
        ctlWr[n] = (regSel == 2'd2);
      end
    end
  end

  // Tick effects first, then CPU writes override CNT and the CTL control bits; a tick-set READY/OVR beats W1C.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cntD[n]   = cntQ[n];
      limD[n]   = limQ[n];
      enD[n]    = enQ[n];
      autoD[n]  = autoQ[n];
      ienD[n]   = ienQ[n];
      readyD[n] = (readyQ[n] & ~(ctlWr[n] & bus.wdata[3])) | expire[n];
      ovrD[n]   = (ovrQ[n] & ~(ctlWr[n] & bus.wdata[4])) | (expire[n] & readyQ[n]);
`ifdef TIMER_BANK_CAPTURE_EN
      capD[n]   = capQ[n];
      if (ctlWr[n] && bus.wdata[5]) capD[n] = cntQ[n];
`endif
      if (tick && enQ[n]) begin
        if (expire[n]) begin
          cntD[n] = '0;
          if (!autoQ[n]) enD[n] = 1'b0;
        end else begin
          cntD[n] = cntQ[n] + CNT_W'(1);
        end
      end
      if (cntWr[n]) cntD[n] = bus.wdata[CNT_W-1:0];
      if (limWr[n]) limD[n] = bus.wdata[CNT_W-1:0];
      if (ctlWr[n]) begin
        enD[n]   = bus.wdata[0];
        autoD[n] = bus.wdata[1];
        ienD[n]  = bus.wdata[2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescQ <= '0;
      enQ    <= '0;
      autoQ  <= '0;
      ienQ   <= '0;
      readyQ <= '0;
      ovrQ   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cntQ[n] <= '0;
        limQ[n] <= '1;
`ifdef TIMER_BANK_CAPTURE_EN
        capQ[n] <= '0;
`endif
      end
    end else begin
      prescQ <= prescD;
      enQ    <= enD;
      autoQ  <= autoD;
      ienQ   <= ienD;
      readyQ <= readyD;
      ovrQ   <= ovrD;
      for (int n = 0; n < NUM_CH; n++) begin
        cntQ[n] <= cntD[n];
        limQ[n] <= limD[n];
`ifdef TIMER_BANK_CAPTURE_EN
        capQ[n] <= capD[n];
`endif
      end
    end
  end

  always_comb begin
    rdataC = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (hit && (chSel == 4'(n))) begin
        case (regSel)
          2'd0: rdataC = 32'(cntQ[n]);
          2'd1: rdataC = 32'(limQ[n]);
          2'd2: rdataC = {26'd0, 1'b0, ovrQ[n], readyQ[n], ienQ[n], autoQ[n], enQ[n]};
`ifdef TIMER_BANK_CAPTURE_EN
          default: rdataC = 32'(capQ[n]);
`else
          default: rdataC = '0;
`endif
        endcase
      end
    end
  end

  // Walk downwards so the lowest pending channel is the last (winning) assignment.
  always_comb begin
    pend = readyQ & ienQ;
    idnC = 4'hF;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (pend[n]) idnC = 4'(n + 1);
    end
  end

  assign bus.rdata = rdataC;
  assign bus.rsel  = hit;
  assign bus.irq   = bus.ie & (|pend);
  assign bus.idn   = idnC;
endmodule

// File: tb/tb_mmio_timer_bank.sv
// Self-checking bench for mmio_timer_bank: a per-channel behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mmio_timer_bank;
  localparam int          NCH  = 4;
  localparam int          PRE  = 4;
  localparam logic [31:0] BASE = 32'hF0000020;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] lim;
    logic [31:0] cap;
    logic        en;
    logic        rel;
    logic        ien;
    logic        rdy;
    logic        ovr;
  } chan_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mmio_timer_bank_if bus();

  chan_t m [NCH];
  int    edgeCnt;
  int    checks = 0;
  int    errors = 0;
  bit    cmpOn  = 1'b0;

  always #5 clk = ~clk;

  mmio_timer_bank #(
    .NUM_CH(NCH), .CNT_W(32), .BASE_ADDR(BASE), .PRESCALE(PRE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic bit inBlock(logic [31:0] a);
    return (a - BASE) < 32'(16 * NCH);
  endfunction

  function automatic int chOf(logic [31:0] a);
    return int'((a - BASE) / 32'd16);
  endfunction

  function automatic int regOf(logic [31:0] a);
    return int'(((a - BASE) % 32'd16) / 32'd4);
  endfunction

  function automatic chan_t resetCh();
    chan_t r;
    r = '0;
    r.lim = 32'hFFFF_FFFF;
    return r;
  endfunction

  // One channel's next state from the register-level rules: tick effects, then the CPU write.
  function automatic chan_t stepCh(chan_t c, bit tick, bit wr, int rg, logic [31:0] wd);
    chan_t r;
    bit fired;
    r = c;
    fired = 1'b0;
    if (tick && c.en) begin
      if (c.cnt == c.lim) begin
        fired = 1'b1;
        r.rdy = 1'b1;
        if (c.rdy) r.ovr = 1'b1;
        r.cnt = 32'd0;
        if (!c.rel) r.en = 1'b0;
      end else begin
        r.cnt = c.cnt + 32'd1;
      end
    end
    if (wr) begin
      case (rg)
        0: r.cnt = wd;
        1: r.lim = wd;
        2: begin
          r.en  = wd[0];
          r.rel = wd[1];
          r.ien = wd[2];
          if (wd[3] && !fired) r.rdy = 1'b0;
          if (wd[4] && !(fired && c.rdy)) r.ovr = 1'b0;
`ifdef TIMER_BANK_CAPTURE_EN
          if (wd[5]) r.cap = c.cnt;
`endif
        end
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] expRdata(logic [31:0] a);
    chan_t c;
    if (!inBlock(a)) return 32'd0;
    c = m[chOf(a)];
    case (regOf(a))
      0: return c.cnt;
      1: return c.lim;
      2: return {26'd0, 1'b0, c.ovr, c.rdy, c.ien, c.rel, c.en};
      default: return c.cap;
    endcase
  endfunction

  function automatic logic [3:0] expIdn();
    for (int n = 0; n < NCH; n++) begin
      if (m[n].rdy && m[n].ien) return 4'(n + 1);
    end
    return 4'hF;
  endfunction

  function automatic logic expIrq(logic ie);
    logic any;
    any = 1'b0;
    for (int n = 0; n < NCH; n++) any = any | (m[n].rdy & m[n].ien);
    return ie & any;
  endfunction

  // Model state advances on the same edges as the DUT and resets with it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edgeCnt <= 0;
      for (int n = 0; n < NCH; n++) m[n] <= resetCh();
    end else begin
      edgeCnt <= edgeCnt + 1;
      for (int n = 0; n < NCH; n++) begin
        m[n] <= stepCh(m[n], ((edgeCnt + 1) % PRE) == 0,
                       bus.we && inBlock(bus.abus) && (chOf(bus.abus) == n),
                       regOf(bus.abus), bus.wdata);
      end
    end
  end

  task automatic checkOutput(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Every cycle, the DUT's combinational outputs must agree with the model for whatever is on abus.
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("model_rsel",  {31'd0, bus.rsel}, {31'd0, inBlock(bus.abus)});
      checkOutput("model_rdata", bus.rdata, expRdata(bus.abus));
      checkOutput("model_irq",   {31'd0, bus.irq}, {31'd0, expIrq(bus.ie)});
      checkOutput("model_idn",   {28'd0, bus.idn}, {28'd0, expIdn()});
    end
  end

  task automatic waitCycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic [31:0] a, logic [31:0] d);
    bus.abus  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    waitCycles(1);
    bus.we    = 1'b0;
  endtask

  task automatic readExpect(logic [31:0] a, logic [31:0] exp, string nm);
    bus.abus = a;
    @(negedge clk);
    checkOutput(nm, bus.rdata, exp);
    waitCycles(1);
  endtask

  task automatic sampleFlags(logic expI, logic [3:0] expD, string nm);
    @(negedge clk);
    checkOutput({nm, "_irq"}, {31'd0, bus.irq}, {31'd0, expI});
    checkOutput({nm, "_idn"}, {28'd0, bus.idn}, {28'd0, expD});
    waitCycles(1);
  endtask

  task automatic pollBit(logic [31:0] a, int b, int maxc, string nm);
    bit found;
    found = 1'b0;
    bus.abus = a;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (bus.rdata[b] === 1'b1) found = 1'b1;
    end
    checkOutput(nm, {31'd0, found}, 32'd1);
    waitCycles(1);
  endtask

  // Leaves the bench one cycle before an edge on which the shared prescaler ticks.
  task automatic alignBeforeTick();
    for (int i = 0; i < PRE && ((edgeCnt + 1) % PRE) != 0; i++) waitCycles(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.abus  = 32'd0;
    bus.wdata = 32'd0;
    bus.we    = 1'b0;
    bus.ie    = 1'b1;
    waitCycles(3);
    rst   = 1'b1;
    cmpOn = 1'b1;

    // Reset state and address decode boundaries.
    sampleFlags(1'b0, 4'hF, "rst_flags");
    readExpect(BASE + 32'h08, 32'h0000_0000, "rst_ctl0");
    readExpect(BASE + 32'h06, 32'hFFFF_FFFF, "rst_lim0_lowbits");
    readExpect(32'h0000_0000, 32'h0000_0000, "unsel_rdata");
    bus.abus = BASE + 32'h40;
    @(negedge clk);
    checkOutput("unsel_rsel_above", {31'd0, bus.rsel}, 32'd0);
    waitCycles(1);

    // Auto-reload channel 0 with LIM=3 expires after four ticks and keeps running.
    applyStimulus(BASE + 32'h04, 32'd3);
    applyStimulus(BASE + 32'h08, 32'h7);
    pollBit(BASE + 32'h08, 3, 40, "ready0_set");
    readExpect(BASE + 32'h00, 32'd0, "cnt0_after_expiry");
    readExpect(BASE + 32'h08, 32'hF, "ctl0_auto_en");
    sampleFlags(1'b1, 4'h1, "ch0_pend");

    // Second expiry with READY still set raises OVR; W1C of both then clears them.
    pollBit(BASE + 32'h08, 4, 40, "ovr0_set");
    readExpect(BASE + 32'h08, 32'h1F, "ctl0_ovr");
    applyStimulus(BASE + 32'h08, 32'h18);
    readExpect(BASE + 32'h08, 32'h0, "ctl0_w1c");
    sampleFlags(1'b0, 4'hF, "ch0_cleared");

    // One-shot channel 1 stops itself and freezes CNT at 0.
    applyStimulus(BASE + 32'h18, 32'h5);
    applyStimulus(BASE + 32'h14, 32'd2);
    pollBit(BASE + 32'h18, 3, 60, "ready1_set");
    readExpect(BASE + 32'h18, 32'hC, "ctl1_oneshot");
    readExpect(BASE + 32'h10, 32'd0, "cnt1_zero");
    waitCycles(10);
    readExpect(BASE + 32'h10, 32'd0, "cnt1_frozen");
    sampleFlags(1'b1, 4'h2, "ch1_pend");
    applyStimulus(BASE + 32'h18, 32'h8);
    readExpect(BASE + 32'h18, 32'h0, "ctl1_w1c");
    sampleFlags(1'b0, 4'hF, "ch1_cleared");

    // Priority encoding of idn across channels 2 and 3, and ie gating only irq.
    applyStimulus(BASE + 32'h24, 32'd0);
    applyStimulus(BASE + 32'h34, 32'd0);
    applyStimulus(BASE + 32'h28, 32'h5);
    applyStimulus(BASE + 32'h38, 32'h5);
    waitCycles(10);
    sampleFlags(1'b1, 4'h3, "ch23_pend");
    applyStimulus(BASE + 32'h28, 32'h8);
    sampleFlags(1'b1, 4'h4, "ch3_only");
    bus.ie = 1'b0;
    sampleFlags(1'b0, 4'h4, "ie_off");
    bus.ie = 1'b1;
    applyStimulus(BASE + 32'h38, 32'h8);
    sampleFlags(1'b0, 4'hF, "ch3_cleared");

    // A CNT write on a tick edge wins over the increment.
    applyStimulus(BASE + 32'h04, 32'd100);
    applyStimulus(BASE + 32'h08, 32'h1);
    alignBeforeTick();
    applyStimulus(BASE + 32'h00, 32'h10);
    readExpect(BASE + 32'h00, 32'h10, "cnt0_write_prio");
    waitCycles(7);
    readExpect(BASE + 32'h00, 32'h12, "cnt0_after_two_ticks");

    // Asynchronous reset in mid-count.
    applyStimulus(BASE + 32'h14, 32'd0);
    applyStimulus(BASE + 32'h18, 32'h5);
    waitCycles(6);
    sampleFlags(1'b1, 4'h2, "pre_rst_pend");
    bus.abus = BASE;
    #1 rst = 1'b0;
    #1;
    checkOutput("async_rst_cnt0", bus.rdata, 32'd0);
    checkOutput("async_rst_irq", {31'd0, bus.irq}, 32'd0);
    checkOutput("async_rst_idn", {28'd0, bus.idn}, 32'hF);
    bus.abus = BASE + 32'h04;
    #1;
    checkOutput("async_rst_lim0", bus.rdata, 32'hFFFF_FFFF);
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);

    // CAP snapshot of the running count, or an always-zero but still selected slot.
    applyStimulus(BASE + 32'h04, 32'd100);
    applyStimulus(BASE + 32'h08, 32'h1);
    alignBeforeTick();
    applyStimulus(BASE + 32'h00, 32'd5);
    applyStimulus(BASE + 32'h08, 32'h27);
    bus.abus = BASE + 32'h0C;
    @(negedge clk);
    checkOutput("cap0_rsel", {31'd0, bus.rsel}, 32'd1);
`ifdef TIMER_BANK_CAPTURE_EN
    checkOutput("cap0_value", bus.rdata, 32'd5);
    waitCycles(1);
    waitCycles(8);
    readExpect(BASE + 32'h00, 32'd7, "cnt0_continues");
`else
    checkOutput("cap0_absent", bus.rdata, 32'd0);
    waitCycles(1);
`endif
    waitCycles(4);

    cmpOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_timer_bank.md
MMIO_TIMER_BANK -- requirements
Module: mmio_timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..15).
REQ-002 SHALL have parameter CNT_W, default 32, counter/limit width in bits (<=32).
REQ-003 SHALL have parameter BASE_ADDR, default 32'hF0000020, byte address of channel 0 register block.
REQ-004 SHALL have parameter PRESCALE, default 50000, clk cycles per timer tick (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port abus  input  32  byte address from pipeline.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port we  input  1  store strobe, one cycle per write.
REQ-010 SHALL have port ie  input  1  global interrupt enable.
REQ-011 SHALL have port rdata  output  32  read data for addressed register, 0 when not selected.
REQ-012 SHALL have port rsel  output  1  high when abus hits this block (bus-drive enable).
REQ-013 SHALL have port irq  output  1  interrupt request.
REQ-014 SHALL have port idn  output  4  pending device number.

Function
REQ-015 SHALL map channel n at BASE_ADDR+16n: +0 CNT, +4 LIM, +8 CTL, +12 CAP; abus[1:0] ignored; other addresses not selected.
REQ-016 SHALL define CTL bits: [0] EN, [1] AUTO (reload), [2] IEN, [3] READY (sticky), [4] OVR (sticky), [5] CAPSTB (write-only, reads 0); other bits read 0.
REQ-017 SHALL return rdata/rsel combinationally from abus in the same cycle; CNT/LIM zero-extended to 32 bits.
REQ-018 SHALL write CNT/LIM/CTL[2:0] from wdata[CNT_W-1:0] on the clk edge where we=1 and address matches.
REQ-019 SHALL clear READY/OVR when a CTL write has that bit =1 (write-1-to-clear); writing 0 leaves it unchanged.
REQ-020 SHALL run one shared prescaler 0..PRESCALE-1, asserting tick for one cycle when it wraps to 0.
REQ-021 SHALL, on tick with EN=1 and CNT!=LIM, increment CNT by 1 (mod 2^CNT_W).
REQ-022 SHALL, on tick with EN=1 and CNT==LIM, set READY, set OVR if READY was already 1, load CNT=0, and clear EN if AUTO=0.
REQ-023 SHALL give a CPU write to CNT or CTL priority over a same-cycle tick update of that channel; READY set by tick and W1C in the same cycle: set wins.
REQ-024 SHALL hold CNT frozen when EN=0; LIM=0 with EN=1 expires every tick.
REQ-025 SHALL drive irq = ie AND OR over channels of (READY AND IEN), combinational.
REQ-026 SHALL drive idn = 4'h1+n for lowest-index channel n with READY AND IEN, else 4'hF; independent of ie.

Reset
REQ-027 SHALL, while rst=0, clear prescaler, all CNT, CAP and CTL bits to 0, and set all LIM to all-ones.
REQ-028 SHALL, on rst deassertion, produce irq=0, idn=4'hF, rdata=0 for unselected addresses; first tick PRESCALE cycles later.

Configuration
REQ-029 SHALL, with macro TIMER_BANK_CAPTURE_EN defined, copy CNT (pre-update value) into CAP on a CTL write with wdata[5]=1, readable at +12.
REQ-030 SHALL, without TIMER_BANK_CAPTURE_EN, omit CAP storage; +12 remains selected, reads 0, and CTL bit5 has no effect.

Verification (PRESCALE=4, NUM_CH=4)
REQ-031 SHALL check: reset, LIM0=3, CTL0=0x7 -> READY0 after 16 clk ticks-window (4 ticks), irq=1 with ie=1, idn=4'h1, CNT0=0, EN stays 1.
REQ-032 SHALL check: CTL1=0x5 (one-shot), LIM1=2 -> after expiry EN1=0, CNT1=0 frozen, READY1=1; W1C write 0x8 -> READY1=0, irq=0.
REQ-033 SHALL check: ch2 and ch3 both pending -> idn=4'h3; clear ch2 -> idn=4'h4; ie=0 -> irq=0, idn unchanged.
REQ-034 SHALL check: READY0 not cleared across two expiries -> OVR0=1; CTL0 write 0x18 clears both.
REQ-035 SHALL check: CNT write 0x10 in the cycle of a tick -> CNT reads 0x10 next cycle; rst pulsed mid-count -> CNT=0, LIM=all-ones, irq=0 asynchronously.
REQ-036 SHALL check (TIMER_BANK_CAPTURE_EN): CNT0 running at 5, CTL0 write 0x27 -> CAP0 reads 5, count continues; without macro +12 reads 0.
